// File: rtl/vga_scan_streamer_if.sv
// Framebuffer word request/return bundle between the scan streamer and the VGA data controller.
interface vga_scan_streamer_if;
    logic [31:0] data_to_VGA;
    logic        data_valid;
    logic        VGA_request;
    logic [31:0] VGA_request_address;

    modport master (
        output VGA_request,
        output VGA_request_address,
        input  data_to_VGA,
        input  data_valid
    );

    modport slave (
        input  VGA_request,
        input  VGA_request_address,
        output data_to_VGA,
        output data_valid
    );
endinterface

// File: rtl/vga_scan_streamer.sv
// VGA scan timing generator that fetches framebuffer words one ahead of the beam
// and serializes each 32-bit word into four RGB332 pixels, MSB first.
module vga_scan_streamer #(
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          V_SHIFT   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    vga_scan_streamer_if.master        mem,
    output logic [9:0]                 h_count,
    output logic [9:0]                 v_count,
    output logic [1:0]                 VGA_state,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       pixel_en,
    output logic [7:0]                 pixel,
    output logic                       underrun
);

    localparam logic [9:0]  H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0]  H_ACT_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_ACT_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  H_FETCH_END = 10'(H_SYNC + H_BP + H_ACTIVE - 8);
    localparam logic [9:0]  H_LAST      = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [9:0]  V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0]  V_ACT_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_ACT_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0]  V_LAST      = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [31:0] LINE_WORDS  = 32'(H_ACTIVE / 4);

    function automatic logic [31:0] line_base(input logic [9:0] v);
        logic [9:0] line_idx;
        line_idx = (v - V_ACT_START) >> V_SHIFT;
        return BASE_ADDR + 32'(line_idx) * LINE_WORDS;
    endfunction

    logic [31:0] shift_word;
    logic [31:0] next_word;
    logic        next_valid;
    logic        outstanding;

    logic [9:0]  h_next;
    logic [9:0]  v_next;
    logic [9:0]  p_next;
    logic [1:0]  phase;
    logic        h_act;
    logic        v_act;
    logic        v_act_next;
    logic        load;
    logic        prefetch_next;
    logic        fetch_next;
    logic [31:0] load_word;
    logic [31:0] addr_next;
    logic [7:0]  pixel_next;

    always_comb begin
        if (h_count < H_SYNC_END)
            VGA_state = 2'd0;
        else if (h_count < H_ACT_START)
            VGA_state = 2'd1;
        else if (h_count < H_ACT_END)
            VGA_state = 2'd2;
        else
            VGA_state = 2'd3;
    end

    // Request decisions are made on the next counter values so the strobe and
    // address are registered yet line up with the h_count they belong to.
    always_comb begin
        h_next = (h_count == H_LAST) ? 10'd0 : h_count + 10'd1;
        v_next = v_count;
        if (h_count == H_LAST)
            v_next = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;

        h_act      = (h_count >= H_ACT_START) && (h_count < H_ACT_END);
        v_act      = (v_count >= V_ACT_START) && (v_count < V_ACT_END);
        v_act_next = (v_next >= V_ACT_START) && (v_next < V_ACT_END);
        phase      = 2'(h_count - H_ACT_START);
        p_next     = h_next - H_ACT_START;

        load      = h_act && v_act && (phase == 2'd0);
        load_word = next_valid ? next_word : 32'd0;

        prefetch_next = v_act_next && (h_next == H_SYNC_END);
        fetch_next    = v_act_next && (h_next >= H_ACT_START) &&
                        (h_next <= H_FETCH_END) && (p_next[1:0] == 2'd0);
        addr_next     = line_base(v_next) +
                        (prefetch_next ? 32'd0 : 32'(p_next[9:2]) + 32'd1);

        pixel_next = 8'd0;
        case (phase)
            2'd0: pixel_next = load_word[31:24];
            2'd1: pixel_next = shift_word[23:16];
            2'd2: pixel_next = shift_word[15:8];
            2'd3: pixel_next = shift_word[7:0];
            default: pixel_next = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_count                 <= 10'd0;
            v_count                 <= 10'd0;
            hsync                   <= 1'b1;
            vsync                   <= 1'b1;
            pixel_en                <= 1'b0;
            pixel                   <= 8'd0;
            underrun                <= 1'b0;
            mem.VGA_request         <= 1'b0;
            mem.VGA_request_address <= BASE_ADDR;
            shift_word              <= 32'd0;
            next_word               <= 32'd0;
            next_valid              <= 1'b0;
            outstanding             <= 1'b0;
        end else begin
            h_count  <= h_next;
            v_count  <= v_next;
            hsync    <= (h_count >= H_SYNC_END);
            vsync    <= (v_count >= V_SYNC_END);
            pixel_en <= h_act && v_act;
            pixel    <= (h_act && v_act) ? pixel_next : 8'd0;

            mem.VGA_request <= prefetch_next || fetch_next;
            if (prefetch_next || fetch_next)
                mem.VGA_request_address <= addr_next;

            // A load consumes the buffered word; a same-cycle return refills it afterwards.
            if (load) begin
                shift_word <= load_word;
                next_valid <= 1'b0;
                if (!next_valid)
                    underrun <= 1'b1;
            end
            if (mem.data_valid && outstanding) begin
                next_word   <= mem.data_to_VGA;
                next_valid  <= 1'b1;
                outstanding <= 1'b0;
            end
            if (prefetch_next || fetch_next)
                outstanding <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_scan_streamer.sv
// Directed bench: default-timing streamer, a V_SHIFT=1 variant and a shrunken-timing
// variant for whole-frame behaviour and abandoned-request handling.
module tb_vga_scan_streamer;

    logic clk;
    logic rst_a;
    logic rst_b;

    vga_scan_streamer_if bus_a ();
    vga_scan_streamer_if bus_v ();
    vga_scan_streamer_if bus_s ();

    logic [9:0] a_h, a_v, v_h, v_v, s_h, s_v;
    logic [1:0] a_state, v_state, s_state;
    logic       a_hs, a_vs, a_en, a_ur;
    logic       v_hs, v_vs, v_en, v_ur;
    logic       s_hs, s_vs, s_en, s_ur;
    logic [7:0] a_pix, v_pix, s_pix;

    vga_scan_streamer dut (
        .clk(clk), .rst(rst_a), .mem(bus_a),
        .h_count(a_h), .v_count(a_v), .VGA_state(a_state),
        .hsync(a_hs), .vsync(a_vs), .pixel_en(a_en), .pixel(a_pix), .underrun(a_ur)
    );

    vga_scan_streamer #(.BASE_ADDR(32'h1000), .V_SHIFT(1)) dut_vs (
        .clk(clk), .rst(rst_a), .mem(bus_v),
        .h_count(v_h), .v_count(v_v), .VGA_state(v_state),
        .hsync(v_hs), .vsync(v_vs), .pixel_en(v_en), .pixel(v_pix), .underrun(v_ur)
    );

    vga_scan_streamer #(.H_SYNC(4), .H_BP(4), .H_ACTIVE(16), .H_FP(4),
                        .V_SYNC(2), .V_BP(3), .V_ACTIVE(4), .V_FP(2)) dut_sm (
        .clk(clk), .rst(rst_b), .mem(bus_s),
        .h_count(s_h), .v_count(s_v), .VGA_state(s_state),
        .hsync(s_hs), .vsync(s_vs), .pixel_en(s_en), .pixel(s_pix), .underrun(s_ur)
    );

    int n_checks;
    int n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] pick(input logic [31:0] w, input int i);
        logic [31:0] t;
        t = w >> (8 * (3 - i));
        return t[7:0];
    endfunction

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Memory models: return two cycles after the request is seen.
    logic        resp_en_a, inject_a, a_s0, a_s1;
    logic [31:0] withhold_a;
    logic        resp_en_s, inject_s, s_s0, s_s1;
    logic [31:0] s_s0_a, s_s1_a;

    initial begin
        bus_a.data_valid  = 1'b0;
        bus_a.data_to_VGA = 32'd0;
        a_s0 = 1'b0;
        a_s1 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en_a) begin
                bus_a.data_valid  = a_s1;
                bus_a.data_to_VGA = a_s1 ? 32'h6AAA5556 : 32'd0;
                a_s1 = a_s0;
                a_s0 = bus_a.VGA_request && (bus_a.VGA_request_address != withhold_a);
            end else begin
                bus_a.data_valid  = inject_a;
                bus_a.data_to_VGA = 32'hDEADBEEF;
                a_s0 = 1'b0;
                a_s1 = 1'b0;
            end
        end
    end

    initial begin
        bus_s.data_valid  = 1'b0;
        bus_s.data_to_VGA = 32'd0;
        s_s0 = 1'b0;
        s_s1 = 1'b0;
        s_s0_a = 32'd0;
        s_s1_a = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en_s) begin
                bus_s.data_valid  = s_s1;
                bus_s.data_to_VGA = s_s1 ? {8'hC3, s_s1_a[7:0], 8'h3C, ~s_s1_a[7:0]} : 32'd0;
                s_s1   = s_s0;
                s_s1_a = s_s0_a;
                s_s0   = bus_s.VGA_request;
                s_s0_a = bus_s.VGA_request_address;
            end else begin
                bus_s.data_valid  = inject_s;
                bus_s.data_to_VGA = 32'hFFFFFFFF;
                s_s0 = 1'b0;
                s_s1 = 1'b0;
            end
        end
    end

    initial begin
        bus_v.data_valid  = 1'b0;
        bus_v.data_to_VGA = 32'd0;
    end

    logic [7:0]  exp_pat [4] = '{8'h6A, 8'hAA, 8'h55, 8'h56};
    int          st_cnt [4];
    int          hs_low, hs_first, h_max, wrapped, cyc;
    int          blank_req, n35, ok35, n36, ok36, en35, good35;
    logic [7:0]  w37 [6];
    logic [31:0] vs_addr [3];
    int          vs_low, s_en_cnt, s_good, s_vmax, p, ln;
    logic [31:0] sa, sw;

    initial begin
        n_checks = 0; n_err = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        resp_en_a = 1'b1; inject_a = 1'b0; withhold_a = 32'hFFFFFFFF;
        resp_en_s = 1'b1; inject_s = 1'b0;
        for (int i = 0; i < 4; i++) st_cnt[i] = 0;
        for (int i = 0; i < 6; i++) w37[i] = 8'hEE;
        for (int i = 0; i < 3; i++) vs_addr[i] = 32'hFFFFFFFF;
        hs_low = 0; hs_first = -1; h_max = 0; wrapped = 0;
        blank_req = 0; n35 = 0; ok35 = 0; n36 = 0; ok36 = 0; en35 = 0; good35 = 0;

        repeat (3) @(negedge clk);
        check("reset_state", {a_h, a_v, a_state, bus_a.VGA_request, a_hs, a_vs, a_en, a_ur, a_pix},
              {10'd0, 10'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        check("reset_addr", bus_a.VGA_request_address, 32'd0);

        rst_a = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            st_cnt[a_state]++;
            if (!a_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(a_h);
            end
            if (int'(a_h) > h_max) h_max = int'(a_h);
            if (a_h == 10'd0) wrapped++;
        end
        check("state_spans", {16'(st_cnt[0]), 16'(st_cnt[1]), 16'(st_cnt[2]), 16'(st_cnt[3])},
              {16'd96, 16'd48, 16'd640, 16'd16});
        check("hsync_low_len", 64'(hs_low), 64'd96);
        check("hsync_first_h", 64'(hs_first), 64'd1);
        check("h_max", 64'(h_max), 64'd799);
        check("h_wrap_v_step", {32'(wrapped), 22'd0, a_v}, {32'd1, 22'd0, 10'd1});

        cyc = 0;
        while (!(a_v == 10'd40 && a_h == 10'd300) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (bus_a.VGA_request && a_v < 10'd35) blank_req++;
            if (bus_a.VGA_request && a_v == 10'd35) begin
                if (bus_a.VGA_request_address == 32'(n35)) ok35++;
                n35++;
            end
            if (bus_a.VGA_request && a_v == 10'd36) begin
                if (bus_a.VGA_request_address == 32'(160 + n36)) ok36++;
                n36++;
            end
            if (bus_v.VGA_request && v_h == 10'd96 && v_v >= 10'd35 && v_v <= 10'd37)
                vs_addr[int'(v_v) - 35] = bus_v.VGA_request_address;
            if (a_v == 10'd35 && a_en) begin
                en35++;
                if (a_pix == exp_pat[(int'(a_h) + 3) % 4]) good35++;
            end
            if (a_v == 10'd37 && a_h == 10'd0) begin
                check("underrun_clean", 64'(a_ur), 64'd0);
                withhold_a = 32'd325;
            end
            if (a_v == 10'd37 && a_h >= 10'd164 && a_h <= 10'd169)
                w37[int'(a_h) - 164] = a_pix;
            if (a_v == 10'd38 && a_h == 10'd0)
                check("underrun_set", 64'(a_ur), 64'd1);
        end
        check("reach_v40_h300", {a_v, a_h}, {10'd40, 10'd300});
        check("no_blank_requests", 64'(blank_req), 64'd0);
        check("line35_addrs", {32'(n35), 32'(ok35)}, {32'd160, 32'd160});
        check("line36_addrs", {32'(n36), 32'(ok36)}, {32'd160, 32'd160});
        check("line35_pixels", {32'(en35), 32'(good35)}, {32'd640, 32'd640});
        check("withheld_pixels", {w37[0], w37[1], w37[2], w37[3], w37[4], w37[5]},
              {8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h6A});
        check("underrun_sticky", 64'(a_ur), 64'd1);
        check("vshift_line35", vs_addr[0], 32'h1000);
        check("vshift_line36", vs_addr[1], 32'h1000);
        check("vshift_line37", vs_addr[2], 32'h10A0);
        check("req_at_300", {bus_a.VGA_request, bus_a.VGA_request_address}, {1'b1, 32'd840});

        resp_en_a = 1'b0;
        rst_a = 1'b1;
        @(negedge clk);
        check("midrun_reset_state", {a_h, a_v, a_state, bus_a.VGA_request, a_hs, a_vs, a_en, a_ur, a_pix},
              {10'd0, 10'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        check("midrun_reset_addr", bus_a.VGA_request_address, 32'd0);
        rst_a = 1'b0;
        inject_a = 1'b1;
        @(negedge clk);
        check("restart_h", {a_h, a_v}, {10'd1, 10'd0});
        inject_a = 1'b0;
        repeat (3) @(negedge clk);
        check("after_reset", {a_h, a_v, a_ur, a_en, a_pix, bus_a.VGA_request, a_hs},
              {10'd4, 10'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
        check("after_reset_addr", bus_a.VGA_request_address, 32'd0);

        vs_low = 0; s_en_cnt = 0; s_good = 0; s_vmax = 0;
        rst_b = 1'b0;
        for (int i = 0; i < 308; i++) begin
            @(negedge clk);
            if (!s_vs) vs_low++;
            if (s_en) begin
                s_en_cnt++;
                p  = int'(s_h) - 9;
                ln = int'(s_v) - 5;
                sa = 32'(4 * ln + (p >>> 2));
                sw = {8'hC3, sa[7:0], 8'h3C, ~sa[7:0]};
                if (s_pix == pick(sw, p & 3)) s_good++;
            end
            if (int'(s_v) > s_vmax) s_vmax = int'(s_v);
        end
        check("frame_vsync_low", 64'(vs_low), 64'd56);
        check("frame_pixels", {32'(s_en_cnt), 32'(s_good)}, {32'd64, 32'd64});
        check("frame_v_wrap", {22'(s_vmax), s_v, s_h}, {22'd10, 10'd0, 10'd0});
        check("frame_underrun", 64'(s_ur), 64'd0);

        cyc = 0;
        while (!(s_v == 10'd5 && s_h == 10'd8) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("sm_request_out", {s_v, s_h, bus_s.VGA_request}, {10'd5, 10'd8, 1'b1});
        resp_en_s = 1'b0;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        inject_s = 1'b1;
        @(negedge clk);
        inject_s = 1'b0;
        cyc = 0;
        while (!(s_v == 10'd5 && s_h == 10'd9) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("late_data_ignored", {s_v, s_h, s_en, s_pix, s_ur},
              {10'd5, 10'd9, 1'b1, 8'd0, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/vga_scan_streamer.md
Name: vga_scan_streamer

Overview:
- Timing-and-pixel source on the display side of the VGA data path.
- Generates the 800x525 scan counters, the h_count and VGA_state values, and word-request addresses, all consumed by VGA_data_controller.
- Accepts returned 32-bit framebuffer words (data_to_VGA), serializes each into four 8-bit RGB332 pixels, and drives HSYNC/VSYNC to the DAC/connector.

Parameters:
- H_SYNC, 96, horizontal sync width in clocks
- H_BP, 48, horizontal back porch clocks
- H_ACTIVE, 640, visible pixels per line (multiple of 4)
- H_FP, 16, horizontal front porch clocks
- V_SYNC, 2, vertical sync lines
- V_BP, 33, vertical back porch lines
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch lines
- BASE_ADDR, 0, word address of framebuffer line 0
- V_SHIFT, 0, active line index right-shift before address math (line replication)

Ports:
- clk  in  1  system clock (25 MHz pixel clock)
- rst  in  1  synchronous, active-high reset
- data_to_VGA  in  32  returned framebuffer word
- data_valid  in  1  data_to_VGA valid this cycle
- h_count  out  10  horizontal counter, 0..799
- v_count  out  10  vertical counter, 0..524
- VGA_state  out  2  horizontal phase: 0 sync, 1 back porch, 2 active, 3 front porch
- VGA_request  out  1  one-cycle word request strobe
- VGA_request_address  out  32  word address; held between requests
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- pixel_en  out  1  pixel output is visible
- pixel  out  8  RGB332 pixel; 0 when pixel_en=0
- underrun  out  1  sticky: a word was needed but had not arrived

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: h_count=0, v_count=0, VGA_state=0, VGA_request=0, VGA_request_address=BASE_ADDR, hsync=1, vsync=1, pixel_en=0, pixel=0, underrun=0. Word buffers are cleared and no request is outstanding.
- Horizontal counter: h_count increments every clock; at 799 it wraps to 0.
- VGA_state decode (combinational from h_count):
  - 0 for h_count < 96
  - 1 for h_count < 144
  - 2 for h_count < 784
  - 3 otherwise
- Vertical counter: v_count increments only on the h wrap; at 524 it wraps to 0.
- Vertical phase order: sync 0..1, back porch 2..34, active 35..514, front porch 515..524.
- Definitions:
  - active line: v_count in 35..514
  - L = (v_count-35) >> V_SHIFT
  - line_base = BASE_ADDR + L*(H_ACTIVE/4), unsigned 32-bit, wraps modulo 2^32
  - p = h_count-144 during active
- Requests, issued on active lines only:
  - Prefetch: at h_count==96, pulse VGA_request with address line_base.
  - During active, at p = 0,4,...,H_ACTIVE-8, pulse VGA_request with address line_base+p/4+1.
  - This gives exactly H_ACTIVE/4 requests per line (160 at defaults). No requests on blanking lines.
- Request tracking: one request is outstanding at a time.
  - data_valid while a request is outstanding writes next_word, sets next_valid, and clears outstanding.
  - data_valid with nothing outstanding is ignored.
  - Required return latency is at most 3 clocks. The prefetch return latency may be up to 47 clocks.
- Serialization: at every p with p%4==0, shift_word <= next_word and next_valid <= 0.
  - If data_valid arrives in the same cycle, the new data lands in next_word after the load. The load uses the old value.
  - If next_valid was 0 at a load, shift_word <= 0 and underrun <= 1.
- Pixel order: most-significant byte first. Pixel p uses shift_word[31-8*(p%4) -: 8].
- Output alignment: pixel, pixel_en, hsync and vsync are registered and reflect the counter values of the previous cycle.
  - pixel_en=1 exactly for cycles following an active h with an active line.
  - hsync=0 for the 96 cycles following h_count 0..95.
  - vsync=0 across lines 0..1, delayed one cycle.
- underrun is cleared only by rst.
- Reset mid-operation: all state returns to reset values on the next edge. A late data_valid from an abandoned request is ignored.

Test Plan:
- Reset then free-run one line → h_count 0..799 wraps; VGA_state spans are 96/48/640/16 clocks; hsync low exactly 96 cycles, starting one cycle after h_count=0.
- Free-run a full frame → v_count wraps 524→0; vsync low for exactly 2 lines (1600 cycles); pixel_en high for 480 lines × 640 cycles.
- Model returning memory[addr] after 2 cycles, with word k = 0x6AAA5556 on line 0 (v_count=35) → pixel sequence 0x6A,0xAA,0x55,0x56 repeating; request addresses 0..159 on line 0 and 160..319 on v_count=36; underrun stays 0.
- Responder withholds data_valid for the word at address 5 → pixels 20..23 of that line are 0x00, underrun=1 and stays 1 through the rest of the frame.
- V_SHIFT=1 → v_count 35 and 36 both issue addresses starting at BASE_ADDR; v_count 37 starts at BASE_ADDR+160.
- Assert rst at h_count=300 with a request outstanding, deliver data_valid one cycle after rst deasserts → all outputs at reset values, data ignored, h_count restarts from 0, underrun=0.
